// File: rtl/exp4_unidade_controle.sv
// -----------------------------------------------------------------------------
// exp4_unidade_controle
//
// Moore control unit for the Exp 4 memory-sequence game. It sequences one
// round: clear the datapath, wait for a play, register it, compare it with the
// ROM word, then advance or finish. A round ends with a hit, a miss or a
// timeout.
//
// Optional feature macro: UC_TIMEOUT_EN
//   defined   -> the espera -> fim_timeout transition is active
//   undefined -> timeout is ignored, fim_timeout is unreachable and
//                db_timeout is tied low
//
// Ports:
//   clock         in   rising-edge system clock
//   reset         in   asynchronous active-high reset, forces inicial
//   iniciar       in   start/restart request (level)
//   jogada_feita  in   one-cycle play pulse from the datapath edge detector
//   igual         in   ROM data equals the registered play
//   fimC          in   address counter at its last position
//   timeout       in   timeout counter terminal count
//   zeraC         out  synchronous clear of the address counter
//   contaC        out  address counter enable
//   zeraR         out  play register clear
//   registrarR    out  play register load
//   zera_timeout  out  synchronous clear of the timeout counter
//   pronto        out  round finished (any outcome)
//   acertou       out  round finished, whole sequence matched
//   errou         out  round finished on a mismatch
//   db_timeout    out  round finished by timeout
//   db_estado     out  current state encoding (debug)
// -----------------------------------------------------------------------------
module exp4_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registrarR,
    output logic       zera_timeout,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARACAO  = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARACAO  = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTO  = 4'b1010,
        FIM_ERRO    = 4'b1110,
        FIM_TIMEOUT = 4'b1111
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;
    logic    timeout_ativo_s;

`ifdef UC_TIMEOUT_EN
    assign timeout_ativo_s = timeout;
`else
    // Without the feature the terminal count never ends a wait.
    assign timeout_ativo_s = 1'b0;
`endif

    // State register; reset is asynchronous so a mid-round reset takes effect at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d = PREPARACAO;
                end else begin
                    estado_d = INICIAL;
                end
            end
            PREPARACAO: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A play wins over a coincident timeout.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (timeout_ativo_s) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fimC) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                estado_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                // A held iniciar restarts every time a final state is reached.
                if (iniciar) begin
                    estado_d = PREPARACAO;
                end else begin
                    estado_d = estado_q;
                end
            end
            default: begin
                // Unused encodings recover to inicial.
                estado_d = INICIAL;
            end
        endcase
    end

    // Moore output decode from the current state only.
    always_comb begin
        zeraC        = 1'b0;
        contaC       = 1'b0;
        zeraR        = 1'b0;
        registrarR   = 1'b0;
        zera_timeout = 1'b1;
        pronto       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        db_timeout   = 1'b0;
        case (estado_q)
            INICIAL: begin
                zera_timeout = 1'b1;
            end
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA: begin
                // Only state where the timeout counter is allowed to run.
                zera_timeout = 1'b0;
            end
            REGISTRA: begin
                registrarR = 1'b1;
            end
            COMPARACAO: begin
                zera_timeout = 1'b1;
            end
            PROXIMO: begin
                contaC = 1'b1;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
`ifdef UC_TIMEOUT_EN
                db_timeout = 1'b1;
`else
                db_timeout = 1'b0;
`endif
            end
            default: begin
                zera_timeout = 1'b1;
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraC, contaC, zeraR, registrarR, zera_timeout;
    logic       pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

`ifdef UC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    exp4_unidade_controle dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimC         (fimC),
        .timeout      (timeout),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registrarR   (registrarR),
        .zera_timeout (zera_timeout),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .db_timeout   (db_timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Reference round model: the phase of the round is kept as the debug code
    // the specification assigns to it.
    int m_st   = 0;
    int addr   = 0;   // emulated datapath address counter
    int n_conta = 0;  // observed contaC pulses

    function automatic int model_next(input int s, input bit ini, input bit jf,
                                      input bit ig, input bit fc, input bit to);
        if (s == 0)  return ini ? 1 : 0;
        if (s == 1)  return 2;
        if (s == 2)  return jf ? 4 : ((to && TO_EN) ? 15 : 2);
        if (s == 4)  return 5;
        if (s == 5)  return !ig ? 14 : (fc ? 10 : 6);
        if (s == 6)  return 2;
        if (s == 10 || s == 14 || s == 15) return ini ? 1 : s;
        return 0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m_st <= 0;
        else       m_st <= model_next(m_st, iniciar, jogada_feita, igual, fimC, timeout);
    end

    always @(posedge clock) begin
        if (m_st == 1)      addr <= 0;
        else if (m_st == 6) addr <= addr + 1;
    end

    always @(negedge clock) begin
        if (contaC === 1'b1) n_conta <= n_conta + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clock) begin
        int s;
        s = m_st;
        chk("db_estado",    int'(db_estado),    s);
        chk("zeraC",        int'(zeraC),        (s == 1) ? 1 : 0);
        chk("zeraR",        int'(zeraR),        (s == 1) ? 1 : 0);
        chk("registrarR",   int'(registrarR),   (s == 4) ? 1 : 0);
        chk("contaC",       int'(contaC),       (s == 6) ? 1 : 0);
        chk("zera_timeout", int'(zera_timeout), (s == 2) ? 0 : 1);
        chk("pronto",       int'(pronto),       (s == 10 || s == 14 || s == 15) ? 1 : 0);
        chk("acertou",      int'(acertou),      (s == 10) ? 1 : 0);
        chk("errou",        int'(errou),        (s == 14) ? 1 : 0);
        chk("db_timeout",   int'(db_timeout),   (s == 15) ? 1 : 0);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    // Pulse a play and let the round reach its outcome (and espera after proximo).
    task automatic play(input bit ig);
        igual = ig;
        fimC = (addr == 15);
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tick();
        chk("reset_estado", int'(db_estado), 0);
        chk("reset_zera_timeout", int'(zera_timeout), 1);
        reset = 1'b0;
        tick();

        // Full 16-play sequence, all hits.
        start_round();
        chk("espera_after_start", int'(db_estado), 2);
        n_conta = 0;
        for (int i = 0; i < 16; i++) begin
            play(1'b1);
            if (i < 15) tick();
        end
        chk("seq_estado", int'(db_estado), 10);
        chk("seq_pronto", int'(pronto), 1);
        chk("seq_acertou", int'(acertou), 1);
        chk("seq_conta_pulses", n_conta, 15);

        // Single miss.
        start_round();
        n_conta = 0;
        play(1'b0);
        chk("erro_estado", int'(db_estado), 14);
        chk("erro_errou", int'(errou), 1);
        chk("erro_no_conta", n_conta, 0);

        // Restart from fim_erro.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("restart_prep", int'(db_estado), 1);
        chk("restart_zeraC", int'(zeraC), 1);
        chk("restart_zeraR", int'(zeraR), 1);
        tick();
        chk("restart_espera", int'(db_estado), 2);

        // Timeout while waiting.
        timeout = 1'b1;
        tick();
        tick();
        timeout = 1'b0;
        chk("timeout_estado", int'(db_estado), TO_EN ? 15 : 2);
        chk("timeout_db", int'(db_timeout), TO_EN ? 1 : 0);

        // Play and timeout together: the play wins.
        start_round();
        timeout = 1'b1;
        jogada_feita = 1'b1;
        igual = 1'b1;
        fimC = 1'b0;
        tick();
        timeout = 1'b0;
        jogada_feita = 1'b0;
        chk("prio_registra", int'(db_estado), 4);

        // Async reset in comparacao, observed before the next edge.
        tick();
        chk("pre_reset_comparacao", int'(db_estado), 5);
        reset = 1'b1;
        #1;
        chk("async_reset_estado", int'(db_estado), 0);
        chk("async_reset_zera_timeout", int'(zera_timeout), 1);
        chk("async_reset_pronto", int'(pronto), 0);
        chk("async_reset_registrarR", int'(registrarR), 0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized stimulus checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            iniciar      = ($urandom_range(0, 9) == 0);
            jogada_feita = ($urandom_range(0, 2) == 0);
            igual        = ($urandom_range(0, 3) != 0);
            fimC         = ($urandom_range(0, 4) == 0);
            timeout      = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp4_unidade_controle.md
# exp4_unidade_controle

Moore control unit for the Exp 4 memory-sequence game. Consumes the status signals of the Exp 4 datapath (`igual`, `fimC`, `jogada_feita`, `timeout`) and drives its control inputs (`zeraC`, `contaC`, `zeraR`, `registrarR`, timeout-counter clear). It sequences one round: clear, wait for a play, register it, compare it against ROM, advance or finish. The round ends with hit, miss or timeout.

## Interface
Parameters:
- none (state encoding fixed; see Operation)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces state `inicial`
- `iniciar`  in  1  start/restart request, level, sampled on clock edge
- `jogada_feita`  in  1  one-cycle pulse from datapath edge detector
- `igual`  in  1  ROM data == registered play
- `fimC`  in  1  address counter at last position (rco)
- `timeout`  in  1  timeout counter terminal count
- `zeraC`  out  1  synchronous clear of address counter
- `contaC`  out  1  address counter enable
- `zeraR`  out  1  play register clear
- `registrarR`  out  1  play register load
- `zera_timeout`  out  1  synchronous clear of timeout counter
- `pronto`  out  1  round finished (any outcome)
- `acertou`  out  1  round finished, whole sequence matched
- `errou`  out  1  round finished, mismatch
- `db_timeout`  out  1  round finished by timeout
- `db_estado`  out  4  current state encoding, debug

## Operation
- Single 4-bit state register; async reset to `inicial`; all outputs decoded combinationally from state only (Moore).
- Encodings: `inicial`=0000, `preparacao`=0001, `espera`=0010, `registra`=0100, `comparacao`=0101, `proximo`=0110, `fim_acerto`=1010, `fim_erro`=1110, `fim_timeout`=1111. Any other encoding goes to `inicial` on the next edge.
- `inicial`: `iniciar` → `preparacao`; else hold.
- `preparacao`: assert `zeraC`, `zeraR` → `espera` unconditionally.
- `espera`:
  - `jogada_feita` → `registra`.
  - Else `timeout` → `fim_timeout` (see Configuration).
  - Else hold.
  - `jogada_feita` has priority over `timeout` when both are high.
- `registra`: assert `registrarR` → `comparacao`.
- `comparacao`:
  - `!igual` → `fim_erro`.
  - `igual & fimC` → `fim_acerto`.
  - `igual & !fimC` → `proximo`.
- `proximo`: assert `contaC` → `espera`.
- `fim_acerto` / `fim_erro` / `fim_timeout`:
  - `pronto`=1, plus `acertou` / `errou` / `db_timeout` respectively.
  - `iniciar` → `preparacao`; else hold.
- `zera_timeout`=1 in every state except `espera`, so each wait starts from count 0.
- Control outputs not listed for a state are 0.
- Reset values: `zera_timeout`=1; all other outputs 0; `db_estado`=0000.

## Timing
- `iniciar` high at edge k: `preparacao` after k, `espera` after k+1.
- `jogada_feita` at edge k: `registra` after k; register loads at k+1 (`comparacao`); outcome state after k+2.
- Sync ROM data is valid in `comparacao`: the address is stable since `preparacao`/`proximo`, and `espera` lasts at least 1 cycle.
- `contaC` is high exactly 1 cycle per matched non-final play; the address increments at the edge leaving `proximo`.
- Async reset mid-round: state → `inicial` immediately, without waiting for a clock edge. Outputs take their reset values the same way. Counters and registers are not cleared until the next `preparacao`.
- `iniciar` held high in a final state restarts the round every time that state is reached. There is no edge requirement on `iniciar`.

## Configuration
- `UC_TIMEOUT_EN` defined: the `espera` → `fim_timeout` transition is active.
- `UC_TIMEOUT_EN` undefined:
  - `timeout` is ignored; `espera` exits only on `jogada_feita`.
  - `fim_timeout` is unreachable; `db_timeout` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset asserted mid-`comparacao` → `db_estado`=0000 before the next edge; `zera_timeout`=1; other outputs 0.
- `iniciar` 1 cycle, then 16 `jogada_feita` pulses with `igual`=1, `fimC`=1 on the 16th:
  - 15 `contaC` pulses.
  - Ends in `fim_acerto`, `db_estado`=1010, `pronto`=`acertou`=1.
- Start, one play with `igual`=0 → `fim_erro` 2 edges after the pulse; `errou`=1; `contaC` never asserted.
- With `UC_TIMEOUT_EN`, start, no plays, `timeout`=1 in `espera` → `fim_timeout`, `db_timeout`=1, `db_estado`=1111. Without the macro, same stimulus → state stays 0010.
- `jogada_feita` and `timeout` high on the same edge in `espera` → `registra` (0100).
- From `fim_erro`, `iniciar`=1 → `preparacao` with `zeraC`=`zeraR`=1 for 1 cycle, then `espera`.
